pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; CLK and Reset_n are listed first.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 Reset_n  input  1  asynchronous active-low reset.
REQ-004 pcWrite  input  1  update enable; when 0, PC and return stack hold.
REQ-005 pcSrc  input  2  next-PC select: 00 SEQ, 01 BRANCH, 10 JUMP, 11 RETURN.
REQ-006 branchTaken  input  1  qualifies BRANCH; when 0, BRANCH behaves as SEQ.
REQ-007 link  input  1  with JUMP or RETURN, push PC+2 onto the return stack.
REQ-008 irIN  input  16  current instruction word.
REQ-009 pcOUT  output  16  current program counter (registered).
REQ-010 rasEmpty  output  1  return stack holds 0 entries.
REQ-011 rasFull  output  1  return stack holds RAS_DEPTH entries.
REQ-012 rasErr  output  1  sticky flag: overflow or underflow since reset.

Function
REQ-013 Each update (rising CLK, pcWrite=1) SHALL load pcOUT with the next PC in the same edge; latency is one cycle.
REQ-014 SEQ SHALL give pcOUT+2, modulo 2^16.
REQ-015 BRANCH with branchTaken=1 SHALL give pcOUT+2+(sign-extended irIN[7:0] shifted left 1), modulo 2^16.
REQ-016 JUMP SHALL give {pcOUT[15:12], irIN[11:0]}; pcOUT is the current PC, not PC+2.
REQ-017 RETURN with the stack non-empty SHALL give the top stack entry and pop it.
REQ-018 RETURN with the stack empty SHALL hold pcOUT, leave the stack unchanged, and set rasErr.
REQ-019 link=1 with JUMP SHALL push pcOUT+2.
REQ-020 link=1 with SEQ or BRANCH SHALL be ignored.
REQ-021 Return stack SHALL be a LIFO of RAS_DEPTH=4 16-bit entries with a 3-bit occupancy count.
REQ-022 Push when full SHALL discard the oldest entry.
  - count stays at 4.
  - rasErr is set.
  - the new entry becomes the top.
REQ-023 RETURN with link=1 and a non-empty stack SHALL replace the top entry with pcOUT+2.
  - count is unchanged.
  - next PC is the old top.
REQ-024 RETURN with link=1 and an empty stack SHALL follow REQ-018 and SHALL NOT push.
REQ-025 rasEmpty and rasFull SHALL be combinational decodes of the count.
REQ-026 rasErr SHALL clear only on reset.
REQ-027 pcWrite=0 SHALL freeze all state regardless of the other inputs.

Reset
REQ-028 Reset_n low SHALL immediately force, without waiting for CLK:
  - pcOUT=PC_RESET (16'h0000).
  - stack count=0, so rasEmpty=1 and rasFull=0.
  - rasErr=0.
REQ-029 Stack entry contents SHALL be don't-care after reset.
REQ-030 Reset asserted mid-operation SHALL abandon any pending update.
REQ-031 After Reset_n deasserts, the first rising CLK with pcWrite=1 SHALL be the first update.

Structure
REQ-032 Shared package pc_pkg SHALL hold:
  - pcSrc encodings (SEQ, BRANCH, JUMP, RETURN).
  - RAS_DEPTH=4.
  - PC_RESET=16'h0000.
  - PC_INC=2.
REQ-033 The return stack SHALL be one sub-module, return_addr_stack.
  - inputs: push, pop, pushData.
  - outputs: top, empty, full, overflow, underflow.
  - clocked by CLK and Reset_n.
REQ-034 Next-PC selection SHALL be combinational; the only registers are pcOUT, rasErr and the return_addr_stack storage.

Verification
REQ-035 Reset then 3 SEQ updates -> pcOUT = 0x0000, 0x0002, 0x0004, 0x0006; rasEmpty=1.
REQ-036 pcOUT=0x3010, JUMP with link=1, irIN=0x0ABC -> pcOUT=0x3ABC, stack top=0x3012; a following RETURN -> pcOUT=0x3012, rasEmpty=1.
REQ-037 Branch cases from pcOUT=0x0100:
  - BRANCH, branchTaken=1, irIN[7:0]=0xFE -> pcOUT=0x00FE.
  - from 0x00FE, same with branchTaken=0 -> pcOUT=0x0100.
  - from 0xFFFE, SEQ -> pcOUT=0x0000.
REQ-038 Overflow: five linked JUMPs from PCs 0x0000, 0x0010, 0x0020, 0x0030, 0x0040 -> rasFull=1, rasErr=1; four RETURNs yield 0x0042, 0x0032, 0x0022, 0x0012, then rasEmpty=1.
REQ-039 RETURN on empty stack at pcOUT=0x0200 -> pcOUT stays 0x0200, rasErr=1; RETURN with link=1 on top=0x0500 at pcOUT=0x0600 -> pcOUT=0x0500, new top=0x0602.
REQ-040 Reset_n pulsed low between CLK edges with 2 stack entries and pcWrite=1 -> pcOUT=0x0000 and rasEmpty=1 before the next edge; pcWrite=0 cycles leave all state unchanged.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared encodings and constants for the program-counter sequencer
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RETURN = 2'b11
  } pc_src_e;

  localparam int          RAS_DEPTH = 4;
  localparam logic [15:0] PC_RESET  = 16'h0000;
  localparam logic [15:0] PC_INC    = 16'd2;

  // Branch displacement is a signed halfword count taken from the low byte.
  function automatic logic [15:0] branchTarget(input logic [15:0] pc, input logic [7:0] disp);
    return pc + PC_INC + {{7{disp[7]}}, disp, 1'b0};
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - 4-entry LIFO of return addresses; full push drops the oldest
module return_addr_stack
  import pc_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] pushData,
  output logic [15:0] top,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic        underflow
);

  logic [15:0] entries [RAS_DEPTH];
  logic [2:0]  count;
  logic [1:0]  topIdx;
  logic        doPush;
  logic        doPop;
  logic        doReplace;

  assign empty     = (count == 3'd0);
  assign full      = (count == 3'(RAS_DEPTH));
  assign topIdx    = 2'(count - 3'd1);
  assign top       = entries[topIdx];
  assign underflow = pop & empty;
  assign overflow  = push & ~pop & full;
  assign doReplace = push & pop & ~empty;
  assign doPush    = push & ~pop & ~full;
  assign doPop     = pop & ~push & ~empty;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= 3'd0;
    end else if (doPush) begin
      count <= count + 3'd1;
    end else if (doPop) begin
      count <= count - 3'd1;
    end
  end

  // Entry contents are meaningless while count is zero, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (doPush) begin
      entries[count[1:0]] <= pushData;
    end else if (doReplace) begin
      entries[topIdx] <= pushData;
    end else if (overflow) begin
      for (int i = 0; i < RAS_DEPTH - 1; i++) begin
        entries[i] <= entries[i+1];
      end
      entries[RAS_DEPTH-1] <= pushData;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with branch/jump/return selection and return stack
module pc_sequencer
  import pc_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        pcWrite,
  input  logic [1:0]  pcSrc,
  input  logic        branchTaken,
  input  logic        link,
  input  logic [15:0] irIN,
  output logic [15:0] pcOUT,
  output logic        rasEmpty,
  output logic        rasFull,
  output logic        rasErr
);

  logic [15:0] pcPlus2;
  logic [15:0] nextPc;
  logic [15:0] rasTop;
  logic        rasPush;
  logic        rasPop;
  logic        rasOverflow;
  logic        rasUnderflow;
  logic        unusedIrBits;

  assign pcPlus2      = pcOUT + PC_INC;
  assign unusedIrBits = ^irIN[15:12];

  always_comb begin
    nextPc = pcPlus2;
    case (pc_src_e'(pcSrc))
      PC_SEQ:    nextPc = pcPlus2;
      PC_BRANCH: nextPc = branchTaken ? branchTarget(pcOUT, irIN[7:0]) : pcPlus2;
      PC_JUMP:   nextPc = {pcOUT[15:12], irIN[11:0]};
      PC_RETURN: nextPc = rasEmpty ? pcOUT : rasTop;
      default:   nextPc = pcPlus2;
    endcase
  end

  // A linked return on an empty stack must not push; with entries it becomes a top replace.
  assign rasPop  = pcWrite & (pcSrc == PC_RETURN);
  assign rasPush = pcWrite & link &
                   ((pcSrc == PC_JUMP) | ((pcSrc == PC_RETURN) & ~rasEmpty));

  return_addr_stack u_ras (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .push      (rasPush),
    .pop       (rasPop),
    .pushData  (pcPlus2),
    .top       (rasTop),
    .empty     (rasEmpty),
    .full      (rasFull),
    .overflow  (rasOverflow),
    .underflow (rasUnderflow)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pcOUT  <= PC_RESET;
      rasErr <= 1'b0;
    end else if (pcWrite) begin
      pcOUT  <= nextPc;
      rasErr <= rasErr | rasOverflow | rasUnderflow;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table and scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [1:0] SEQ = 2'b00;
  localparam logic [1:0] BR  = 2'b01;
  localparam logic [1:0] JMP = 2'b10;
  localparam logic [1:0] RET = 2'b11;

  typedef struct {
    logic        wr;
    logic [1:0]  src;
    logic        taken;
    logic        lnk;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        e;
    logic        f;
    logic        err;
  } vec_t;

  logic        CLK;
  logic        Reset_n;
  logic        pcWrite;
  logic [1:0]  pcSrc;
  logic        branchTaken;
  logic        link;
  logic [15:0] irIN;
  logic [15:0] pcOUT;
  logic        rasEmpty;
  logic        rasFull;
  logic        rasErr;

  int passed = 0;
  int total  = 0;

  vec_t        tableA[$];
  vec_t        tableB[$];
  logic [18:0] expQ[$];
  string       nameQ[$];

  pc_sequencer dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .pcWrite     (pcWrite),
    .pcSrc       (pcSrc),
    .branchTaken (branchTaken),
    .link        (link),
    .irIN        (irIN),
    .pcOUT       (pcOUT),
    .rasEmpty    (rasEmpty),
    .rasFull     (rasFull),
    .rasErr      (rasErr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input logic wr, input logic [1:0] src, input logic taken,
                              input logic lnk, input logic [15:0] ir, input logic [15:0] pc,
                              input logic e, input logic f, input logic err);
    vec_t v;
    v.wr = wr; v.src = src; v.taken = taken; v.lnk = lnk; v.ir = ir;
    v.pc = pc; v.e = e; v.f = f; v.err = err;
    return v;
  endfunction

  function automatic logic [18:0] dutState();
    return {pcOUT, rasEmpty, rasFull, rasErr};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got pc=%h empty/full/err=%b, expected pc=%h empty/full/err=%b",
                  name, act[18:3], act[2:0], exp[18:3], exp[2:0]);
  endtask

  task automatic applyVec(input vec_t v, input string name);
    @(negedge CLK);
    pcWrite     = v.wr;
    pcSrc       = v.src;
    branchTaken = v.taken;
    link        = v.lnk;
    irIN        = v.ir;
    expQ.push_back({v.pc, v.e, v.f, v.err});
    nameQ.push_back(name);
    @(posedge CLK);
    #1;
    check(nameQ.pop_front(), dutState(), expQ.pop_front());
  endtask

  initial begin
    // sequential, branch and wrap cases, freeze, empty-return and linked-return cases
    tableA.push_back(mk(1, SEQ, 0, 0, 16'h0000, 16'h0002, 1, 0, 0));
    tableA.push_back(mk(1, SEQ, 0, 0, 16'h0000, 16'h0004, 1, 0, 0));
    tableA.push_back(mk(1, SEQ, 0, 0, 16'h0000, 16'h0006, 1, 0, 0));
    tableA.push_back(mk(1, JMP, 0, 0, 16'h0100, 16'h0100, 1, 0, 0));
    tableA.push_back(mk(1, BR,  1, 0, 16'h00FE, 16'h00FE, 1, 0, 0));
    tableA.push_back(mk(1, BR,  0, 0, 16'h00FE, 16'h0100, 1, 0, 0));
    tableA.push_back(mk(1, SEQ, 0, 1, 16'h0000, 16'h0102, 1, 0, 0));
    tableA.push_back(mk(1, BR,  1, 1, 16'h0002, 16'h0108, 1, 0, 0));
    tableA.push_back(mk(1, JMP, 0, 0, 16'h0000, 16'h0000, 1, 0, 0));
    tableA.push_back(mk(1, BR,  1, 0, 16'h00FE, 16'hFFFE, 1, 0, 0));
    tableA.push_back(mk(1, SEQ, 0, 0, 16'h0000, 16'h0000, 1, 0, 0));
    tableA.push_back(mk(0, JMP, 0, 1, 16'h0ABC, 16'h0000, 1, 0, 0));
    tableA.push_back(mk(1, JMP, 0, 0, 16'h0200, 16'h0200, 1, 0, 0));
    tableA.push_back(mk(1, RET, 0, 0, 16'h0000, 16'h0200, 1, 0, 1));
    tableA.push_back(mk(1, RET, 0, 1, 16'h0000, 16'h0200, 1, 0, 1));
    tableA.push_back(mk(1, JMP, 0, 0, 16'h04FE, 16'h04FE, 1, 0, 1));
    tableA.push_back(mk(1, JMP, 0, 1, 16'h0600, 16'h0600, 0, 0, 1));
    tableA.push_back(mk(1, RET, 0, 1, 16'h0000, 16'h0500, 0, 0, 1));
    tableA.push_back(mk(1, RET, 0, 0, 16'h0000, 16'h0602, 1, 0, 1));
    tableA.push_back(mk(1, JMP, 0, 0, 16'h0010, 16'h0010, 1, 0, 1));
    for (int i = 1; i <= 48; i++)
      tableA.push_back(mk(1, BR, 1, 0, 16'h007F, 16'h0010 + 16'(i * 256), 1, 0, 1));
    tableA.push_back(mk(1, JMP, 0, 1, 16'h0ABC, 16'h3ABC, 0, 0, 1));
    tableA.push_back(mk(1, RET, 0, 0, 16'h0000, 16'h3012, 1, 0, 1));
    tableA.push_back(mk(1, JMP, 0, 1, 16'h0100, 16'h3100, 0, 0, 1));
    tableA.push_back(mk(1, JMP, 0, 1, 16'h0200, 16'h3200, 0, 0, 1));

    // overflow drops the oldest entry, then the stack drains and underflows
    tableB.push_back(mk(1, JMP, 0, 0, 16'h0000, 16'h0000, 1, 0, 0));
    tableB.push_back(mk(1, JMP, 0, 1, 16'h0010, 16'h0010, 0, 0, 0));
    tableB.push_back(mk(1, JMP, 0, 1, 16'h0020, 16'h0020, 0, 0, 0));
    tableB.push_back(mk(1, JMP, 0, 1, 16'h0030, 16'h0030, 0, 0, 0));
    tableB.push_back(mk(1, JMP, 0, 1, 16'h0040, 16'h0040, 0, 1, 0));
    tableB.push_back(mk(1, JMP, 0, 1, 16'h0050, 16'h0050, 0, 1, 1));
    tableB.push_back(mk(1, RET, 0, 0, 16'h0000, 16'h0042, 0, 0, 1));
    tableB.push_back(mk(0, RET, 0, 1, 16'h0000, 16'h0042, 0, 0, 1));
    tableB.push_back(mk(1, RET, 0, 0, 16'h0000, 16'h0032, 0, 0, 1));
    tableB.push_back(mk(1, RET, 0, 0, 16'h0000, 16'h0022, 0, 0, 1));
    tableB.push_back(mk(1, RET, 0, 0, 16'h0000, 16'h0012, 1, 0, 1));
    tableB.push_back(mk(1, RET, 0, 0, 16'h0000, 16'h0012, 1, 0, 1));

    Reset_n = 1'b1; pcWrite = 1'b1; pcSrc = SEQ; branchTaken = 1'b0; link = 1'b0; irIN = '0;
    #1 Reset_n = 1'b0;
    #1 check("reset_state", dutState(), {16'h0000, 3'b100});
    repeat (2) @(posedge CLK);
    #1 check("reset_hold", dutState(), {16'h0000, 3'b100});
    @(negedge CLK);
    pcWrite = 1'b0;
    Reset_n = 1'b1;

    foreach (tableA[i]) applyVec(tableA[i], $sformatf("tableA[%0d]", i));

    // asynchronous reset pulse between edges with an update pending
    @(negedge CLK);
    pcWrite = 1'b1; pcSrc = SEQ; link = 1'b0;
    #1 Reset_n = 1'b0;
    #1 check("async_reset", dutState(), {16'h0000, 3'b100});
    #1 Reset_n = 1'b1;
    expQ.push_back({16'h0002, 3'b100});
    nameQ.push_back("first_update_after_reset");
    @(posedge CLK);
    #1 check(nameQ.pop_front(), dutState(), expQ.pop_front());

    foreach (tableB[i]) applyVec(tableB[i], $sformatf("tableB[%0d]", i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
